// File: rtl/mole_pkg.sv
// Shared definitions for the mole spawner: FSM encoding, sizes, LFSR seed and
// issue timeout. Optional spawn cap is enabled by macro MOLE_SPAWN_CAP_EN.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PICK      = 2'd2,
    ISSUE     = 2'd3
  } state_e;

  localparam int          NUM_MOLES     = 8;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [7:0]  ISSUE_TIMEOUT = 8'd255;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting right; steps when advance=1.
module mole_lfsr16
  import mole_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      q <= LFSR_SEED;
    end else if (advance) begin
      q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Raises one hiding mole per spawn tick, chosen by an LFSR-seeded rotating
// priority search. Build option MOLE_SPAWN_CAP_EN limits moles up at once.
//
// state     | meaning
// IDLE      | game stopped, no requests
// WAIT_TICK | waiting for a latched spawn tick
// PICK      | one-cycle search for an available mole
// ISSUE     | control held on last_mole until ack or timeout
module mole_spawner
  import mole_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic        tick,
  input  logic [7:0]  hiding,
  input  logic [3:0]  max_up,
  output logic [7:0]  control,
  output logic        busy,
  output logic [2:0]  last_mole,
  output logic [15:0] spawn_count,
  output logic [7:0]  timeout_count
);

  state_e      state_q, state_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] spawn_q, spawn_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  timer_q, timer_d;
  logic        tick_pend_q, tick_pend_d;

  logic [15:0] lfsr_q;
  logic        sel_found;
  logic [2:0]  sel_idx;
  logic [2:0]  cand_idx;
  logic        pick_ok;
  logic        ack;

  mole_lfsr16 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .advance  (enable),
    .q        (lfsr_q)
  );

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_q[15:3];

  // First hiding mole at or above the random candidate, wrapping mod 8
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_MOLES; k++) begin
      cand_idx = lfsr_q[2:0] + 3'(k);
      if (!sel_found && hiding[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

`ifdef MOLE_SPAWN_CAP_EN
  assign pick_ok = sel_found && (popcount8(~hiding) < max_up);
`else
  logic unused_max_up;
  assign unused_max_up = ^max_up;
  assign pick_ok       = sel_found;
`endif

  assign ack = ~hiding[last_q];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_q      <= '0;
      spawn_q     <= '0;
      tmo_q       <= '0;
      timer_q     <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      spawn_q     <= spawn_d;
      tmo_q       <= tmo_d;
      timer_q     <= timer_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    spawn_d     = spawn_q;
    tmo_d       = tmo_q;
    timer_d     = timer_q;
    tick_pend_d = 1'b0;
    control     = '0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        // Tick is latched for one cycle so control rises two edges after it
        tick_pend_d = tick & ~tick_pend_q;
        if (tick_pend_q) state_d = PICK;
      end
      PICK: begin
        busy = 1'b1;
        if (pick_ok) begin
          last_d  = sel_idx;
          timer_d = ISSUE_TIMEOUT;
          state_d = ISSUE;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      ISSUE: begin
        busy    = 1'b1;
        control = 8'd1 << last_q;
        if (ack) begin
          spawn_d = spawn_q + 16'd1;
          timer_d = '0;
          state_d = WAIT_TICK;
        end else if (timer_q <= 8'd1) begin
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          timer_d = '0;
          state_d = WAIT_TICK;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d     = IDLE;
      timer_d     = '0;
      tick_pend_d = 1'b0;
    end
  end

  assign last_mole     = last_q;
  assign spawn_count   = spawn_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed + randomized self-checking bench for mole_spawner, with a
// behavioural LFSR / rotate-search model of the expected mole choice.
module tb_mole_spawner;

  logic        CLOCK_50;
  logic        resetn;
  logic        enable;
  logic        tick;
  logic [7:0]  hiding;
  logic [3:0]  max_up;
  logic [7:0]  control;
  logic        busy;
  logic [2:0]  last_mole;
  logic [15:0] spawn_count;
  logic [7:0]  timeout_count;

  int checks   = 0;
  int failures = 0;

  int          m_spawn = 0;
  int          m_tmo   = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  mole_spawner dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .enable        (enable),
    .tick          (tick),
    .hiding        (hiding),
    .max_up        (max_up),
    .control       (control),
    .busy          (busy),
    .last_mole     (last_mole),
    .spawn_count   (spawn_count),
    .timeout_count (timeout_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference LFSR: x^16+x^14+x^13+x^11, output taken from the low bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      if (enable) m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  function automatic int exp_sel(input int cand, input logic [7:0] h);
    for (int k = 0; k < 8; k++) begin
      if (h[(cand + k) % 8]) return (cand + k) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Tick, check the chosen mole two edges later, acknowledge after ack_delay cycles
  task automatic spawn_and_check(input string tag, input logic [7:0] h, input int ack_delay);
    int         es;
    logic [7:0] ec;
    hiding = h;
    pulse_tick();
    chk({tag, "_n0_ctrl"}, {24'd0, control}, 32'd0);
    step(1);
    chk({tag, "_pick_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_pick_ctrl"}, {24'd0, control}, 32'd0);
    step(1);
    es = exp_sel(int'(m_prev[2:0]), h);
    ec = 8'd1 << es;
    chk({tag, "_ctrl"}, {24'd0, control}, {24'd0, ec});
    chk({tag, "_last"}, {29'd0, last_mole}, 32'(es));
    if (ack_delay > 0) begin
      step(ack_delay);
      chk({tag, "_hold"}, {24'd0, control}, {24'd0, ec});
    end
    hiding = h & ~ec;
    step(1);
    m_spawn++;
    chk({tag, "_ack_ctrl"}, {24'd0, control}, 32'd0);
    chk({tag, "_ack_spawn"}, {16'd0, spawn_count}, 32'(m_spawn & 16'hFFFF));
    chk({tag, "_ack_tmo"}, {24'd0, timeout_count}, 32'(m_tmo));
    hiding = h;
  endtask

  initial begin
    logic [7:0] acc;
    logic       busy_seen;
    int         es;
    logic [7:0] ec;
    logic [7:0] rh;

    resetn = 1'b0;
    enable = 1'b0;
    tick   = 1'b0;
    hiding = 8'hFF;
    max_up = 4'd8;
    step(3);
    chk("rst_ctrl",  {24'd0, control}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_last",  {29'd0, last_mole}, 32'd0);
    chk("rst_spawn", {16'd0, spawn_count}, 32'd0);
    chk("rst_tmo",   {24'd0, timeout_count}, 32'd0);

    resetn = 1'b1;
    enable = 1'b1;
    step(2);

    // No mole available: ten ticks produce PICK cycles but never a request
    hiding    = 8'h00;
    acc       = '0;
    busy_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      pulse_tick();
      for (int c = 0; c < 3; c++) begin
        acc       = acc | control;
        busy_seen = busy_seen | busy;
        step(1);
      end
    end
    chk("empty_ctrl",  {24'd0, acc}, 32'd0);
    chk("empty_pick",  {31'd0, busy_seen}, 32'd1);
    chk("empty_spawn", {16'd0, spawn_count}, 32'd0);
    chk("empty_tmo",   {24'd0, timeout_count}, 32'd0);

    spawn_and_check("all", 8'hFF, 0);

    for (int i = 0; i < 3; i++) begin
      spawn_and_check("only0", 8'h01, i);
      chk("only0_last", {29'd0, last_mole}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      rh = 8'($urandom_range(1, 255));
      spawn_and_check("rand", rh, int'($urandom_range(0, 6)));
      step(int'($urandom_range(0, 4)));
    end

    // Timeout: control held through ISSUE-entry+254, dropped at +255
    hiding = 8'hFF;
    pulse_tick();
    step(2);
    es = exp_sel(int'(m_prev[2:0]), 8'hFF);
    ec = 8'd1 << es;
    chk("tmo_ctrl", {24'd0, control}, {24'd0, ec});
    step(254);
    chk("tmo_hold254", {24'd0, control}, {24'd0, ec});
    step(1);
    m_tmo++;
    chk("tmo_drop", {24'd0, control}, 32'd0);
    chk("tmo_count", {24'd0, timeout_count}, 32'(m_tmo));
    chk("tmo_spawn", {16'd0, spawn_count}, 32'(m_spawn));

    // Acknowledge on the timeout cycle: acknowledge wins
    pulse_tick();
    step(2);
    es = exp_sel(int'(m_prev[2:0]), 8'hFF);
    ec = 8'd1 << es;
    step(254);
    chk("race_hold254", {24'd0, control}, {24'd0, ec});
    hiding = 8'hFF & ~ec;
    step(1);
    m_spawn++;
    chk("race_ctrl",  {24'd0, control}, 32'd0);
    chk("race_spawn", {16'd0, spawn_count}, 32'(m_spawn));
    chk("race_tmo",   {24'd0, timeout_count}, 32'(m_tmo));
    hiding = 8'hFF;
    step(1);

    // Reset during ISSUE drops everything without waiting for a clock
    pulse_tick();
    step(2);
    chk("rmid_issue", {31'd0, (control != 8'd0)}, 32'd1);
    step(5);
    #2;
    resetn = 1'b0;
    #1;
    chk("rmid_ctrl",  {24'd0, control}, 32'd0);
    chk("rmid_busy",  {31'd0, busy}, 32'd0);
    chk("rmid_last",  {29'd0, last_mole}, 32'd0);
    chk("rmid_spawn", {16'd0, spawn_count}, 32'd0);
    chk("rmid_tmo",   {24'd0, timeout_count}, 32'd0);
    m_spawn = 0;
    m_tmo   = 0;
    step(2);
    resetn = 1'b1;
    step(1);
    chk("rrel_busy", {31'd0, busy}, 32'd0);
    spawn_and_check("postrst", 8'hFF, 1);

    // Enable dropped during ISSUE returns to IDLE on the next edge
    pulse_tick();
    step(2);
    chk("en_issue", {31'd0, (control != 8'd0)}, 32'd1);
    step(3);
    enable = 1'b0;
    step(1);
    chk("en_ctrl",  {24'd0, control}, 32'd0);
    chk("en_busy",  {31'd0, busy}, 32'd0);
    chk("en_spawn", {16'd0, spawn_count}, 32'(m_spawn));
    chk("en_tmo",   {24'd0, timeout_count}, 32'(m_tmo));
    pulse_tick();
    acc = '0;
    for (int c = 0; c < 4; c++) begin
      acc = acc | control | {7'd0, busy};
      step(1);
    end
    chk("en_off_idle", {24'd0, acc}, 32'd0);
    enable = 1'b1;
    step(1);

`ifdef MOLE_SPAWN_CAP_EN
    max_up = 4'd2;
    hiding = 8'hFC;
    acc    = '0;
    for (int t = 0; t < 3; t++) begin
      pulse_tick();
      for (int c = 0; c < 3; c++) begin
        acc = acc | control;
        step(1);
      end
    end
    chk("cap_block_ctrl",  {24'd0, acc}, 32'd0);
    chk("cap_block_spawn", {16'd0, spawn_count}, 32'(m_spawn));
    spawn_and_check("cap_open", 8'hFE, 0);
    max_up = 4'd0;
    hiding = 8'hFF;
    acc    = '0;
    for (int t = 0; t < 3; t++) begin
      pulse_tick();
      for (int c = 0; c < 3; c++) begin
        acc = acc | control;
        step(1);
      end
    end
    chk("cap_zero_ctrl", {24'd0, acc}, 32'd0);
`else
    max_up = 4'd0;
    spawn_and_check("nocap_zero", 8'hFF, 0);
    max_up = 4'd2;
    spawn_and_check("nocap_fc", 8'hFC, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 SHALL have port CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port enable  input  1  game running; 0 returns the FSM to IDLE on the next edge.
REQ-004 SHALL have port tick  input  1  one-cycle spawn-interval strobe from the clock divider.
REQ-005 SHALL have port hiding  input  8  per-mole hiding status, 1 = mole idle and available.
REQ-006 SHALL have port max_up  input  4  cap on moles raised at once; used only under MOLE_SPAWN_CAP_EN.
REQ-007 SHALL have port control  output  8  per-mole go request, one-hot or zero.
REQ-008 SHALL have port busy  output  1  high while in the PICK or ISSUE state.
REQ-009 SHALL have port last_mole  output  3  index of the most recently issued mole.
REQ-010 SHALL have port spawn_count  output  16  count of acknowledged spawns in binary, wrapping at 16'hFFFF to 0.
REQ-011 SHALL have port timeout_count  output  8  count of aborted spawns, saturating at 8'hFF.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_TICK, PICK and ISSUE.
REQ-013 IDLE SHALL go to WAIT_TICK when enable=1; every other state SHALL go to IDLE when enable=0, and control SHALL be 0 from that edge.
REQ-014 WAIT_TICK SHALL go to PICK on the cycle after tick=1 is sampled; a tick outside WAIT_TICK SHALL be ignored and not queued.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance once per cycle whenever enable=1.
REQ-016 PICK (one cycle): candidate = lfsr[2:0]; the selected mole SHALL be the first index i, scanning from candidate upward mod 8, with hiding[i]=1.
REQ-017 If no hiding bit is set in PICK, the block SHALL return to WAIT_TICK with no request and no counter change.
REQ-018 On a successful pick, the block SHALL register the index into last_mole and enter ISSUE.
REQ-019 ISSUE SHALL hold control[last_mole]=1 and all other control bits 0 until hiding[last_mole]=0 is sampled (acknowledge).
REQ-020 On acknowledge, the block SHALL clear control, increment spawn_count and enter WAIT_TICK, all on the same edge.
REQ-021 If no acknowledge arrives within 255 cycles of entering ISSUE, the block SHALL clear control, increment timeout_count (saturating) and enter WAIT_TICK.
REQ-022 If acknowledge and timeout occur on the same cycle, acknowledge SHALL win and timeout_count SHALL be unchanged.
REQ-023 Latency SHALL be: tick sampled at edge N, control asserted after edge N+2.

Reset
REQ-024 While resetn=0, the block SHALL force: state=IDLE, control=0, busy=0, last_mole=0, spawn_count=0, timeout_count=0, LFSR=16'hACE1, ISSUE timer=0.
REQ-025 Reset asserted mid-ISSUE SHALL drop control asynchronously, with no counter update.
REQ-026 After resetn rises, the first state change SHALL occur on the next rising edge.

Configuration
REQ-027 With macro MOLE_SPAWN_CAP_EN defined, PICK SHALL skip the spawn (as in REQ-017) when the popcount of ~hiding is >= max_up.
REQ-028 With MOLE_SPAWN_CAP_EN defined and max_up=0, the block SHALL never issue a spawn.
REQ-029 Without MOLE_SPAWN_CAP_EN, max_up SHALL be ignored and PICK SHALL behave as in REQ-016 and REQ-017.

Structure
REQ-030 A shared package mole_pkg SHALL hold: the state encoding, NUM_MOLES=8, LFSR_SEED=16'hACE1, ISSUE_TIMEOUT=8'd255.
REQ-031 The LFSR SHALL be a separate sub-module, mole_lfsr16, with ports CLOCK_50, resetn, advance and q[15:0].
REQ-032 The priority-rotate search SHALL be combinational logic inside mole_spawner.

Verification
REQ-033 Bench SHALL cover: hiding=8'hFF, enable=1, one tick -> control one-hot 2 cycles after the tick; drop the selected hiding bit -> control=0 and spawn_count=1.
REQ-034 Bench SHALL cover: hiding=8'h00, 10 ticks -> control stays 0, spawn_count=0, timeout_count=0.
REQ-035 Bench SHALL cover: hiding=8'h01 only -> control=8'h01 and last_mole=0 regardless of LFSR value.
REQ-036 Bench SHALL cover: issue with no acknowledge -> control falls exactly 255 cycles after ISSUE entry and timeout_count=1; acknowledge in cycle 255 -> spawn_count increments and timeout_count does not.
REQ-037 Bench SHALL cover: resetn pulled low mid-ISSUE -> control=0 immediately and all counters 0; enable low mid-ISSUE -> IDLE and control=0 on the next edge.
REQ-038 Bench SHALL cover, with MOLE_SPAWN_CAP_EN defined: max_up=2 and hiding=8'hFC -> ticks produce no request; raising hiding to 8'hFE -> the next tick issues.
